// File: rtl/seq_divider_if.sv
// Start/ready/done handshake and operand/result bundle for seq_divider.
interface seq_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Fixed-latency restoring shift-subtract divider, WIDTH steps per operation.
// Define DIV_SIGNED_EN for two's-complement operands (magnitudes run through the unsigned core).
module seq_divider #(
  parameter int WIDTH = 16
) (
  input logic       clock,
  input logic       reset_n,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic [WIDTH:0]   remShift_d;
  logic             geq_d;
  logic [WIDTH-1:0] remNext_d;
  logic [WIDTH-1:0] workNext_d;
  logic [WIDTH-1:0] magA_d;
  logic [WIDTH-1:0] magB_d;
  logic [WIDTH-1:0] qFinal_d;
  logic [WIDTH-1:0] rFinal_d;

`ifdef DIV_SIGNED_EN
  logic negQ_q;
  logic negR_q;
`endif

  // work_q starts as the dividend and fills with quotient bits from the LSB as it shifts.
  always_comb begin
    remShift_d = {rem_q, work_q[WIDTH-1]};
    geq_d      = remShift_d >= {1'b0, div_q};
    remNext_d  = geq_d ? (remShift_d[WIDTH-1:0] - div_q) : remShift_d[WIDTH-1:0];
    workNext_d = {work_q[WIDTH-2:0], geq_d};
`ifdef DIV_SIGNED_EN
    magA_d   = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
    magB_d   = bus.divisor[WIDTH-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;
    qFinal_d = negQ_q ? (~workNext_d + 1'b1) : workNext_d;
    rFinal_d = negR_q ? (~remNext_d + 1'b1)  : remNext_d;
`else
    magA_d   = bus.dividend;
    magB_d   = bus.divisor;
    qFinal_d = workNext_d;
    rFinal_d = remNext_d;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      work_q      <= '0;
      div_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
      negQ_q      <= 1'b0;
      negR_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            dbz_q <= 1'b0;
            if (bus.divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= bus.dividend;
              dbz_q       <= 1'b1;
              state_q     <= FIN;
            end else begin
              work_q  <= magA_d;
              div_q   <= magB_d;
              rem_q   <= '0;
              cnt_q   <= '0;
`ifdef DIV_SIGNED_EN
              negQ_q  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              negR_q  <= bus.dividend[WIDTH-1];
`endif
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          rem_q  <= remNext_d;
          work_q <= workNext_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            quotient_q  <= qFinal_d;
            remainder_q <= rFinal_d;
            state_q     <= FIN;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready       = (state_q == IDLE);
  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == FIN);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=16); signed vectors run when DIV_SIGNED_EN is defined.
module tb_seq_divider;
  logic clock;
  logic reset_n;
  int   checks = 0;
  int   passes = 0;
  int   lat;
  int   busyCnt;
  int   doneCnt;

  seq_divider_if #(.WIDTH(16)) bus ();

  seq_divider #(.WIDTH(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Launch one operation and wait (bounded) for done; lat counts cycles after the accepting edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               output int latency, output int busyCycles);
    @(negedge clock);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clock);
    bus.start  = 1'b0;
    latency    = 1;
    busyCycles = 0;
    while (!bus.done && latency < 40) begin
      if (bus.busy) busyCycles++;
      @(negedge clock);
      latency++;
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    reset_n      = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("rst_ready", bus.ready, 1);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_dbz", bus.div_by_zero, 0);
    checkOutput("rst_q", bus.quotient, 0);
    checkOutput("rst_r", bus.remainder, 0);
    reset_n = 1'b1;

    applyStimulus(16'd1234, 16'd10, lat, busyCnt);
    checkOutput("1234/10_lat", lat, 17);
    checkOutput("1234/10_busy", busyCnt, 16);
    checkOutput("1234/10_q", bus.quotient, 123);
    checkOutput("1234/10_r", bus.remainder, 4);
    checkOutput("1234/10_dbz", bus.div_by_zero, 0);
    checkOutput("fin_ready", bus.ready, 0);
    @(negedge clock);
    checkOutput("done_pulse", bus.done, 0);
    checkOutput("idle_ready", bus.ready, 1);
    checkOutput("hold_q", bus.quotient, 123);

    applyStimulus(16'hFFFF, 16'd1, lat, busyCnt);
    checkOutput("ffff/1_lat", lat, 17);
    checkOutput("ffff/1_q", bus.quotient, 16'hFFFF);
    checkOutput("ffff/1_r", bus.remainder, 0);

    applyStimulus(16'd7, 16'd0, lat, busyCnt);
    checkOutput("7/0_lat", lat, 1);
    checkOutput("7/0_busy", busyCnt, 0);
    checkOutput("7/0_q", bus.quotient, 16'hFFFF);
    checkOutput("7/0_r", bus.remainder, 7);
    checkOutput("7/0_dbz", bus.div_by_zero, 1);

    applyStimulus(16'd3, 16'd10, lat, busyCnt);
    checkOutput("3/10_lat", lat, 17);
    checkOutput("3/10_q", bus.quotient, 0);
    checkOutput("3/10_r", bus.remainder, 3);
    checkOutput("3/10_dbz", bus.div_by_zero, 0);

    // 100/7 with a stray start of 9/3 presented at E5 while running.
    @(negedge clock);
    bus.start = 1'b1; bus.dividend = 16'd100; bus.divisor = 16'd7;
    @(negedge clock);
    bus.start = 1'b0;
    lat = 1;
    repeat (4) begin @(negedge clock); lat++; end
    checkOutput("run_ready", bus.ready, 0);
    bus.start = 1'b1; bus.dividend = 16'd9; bus.divisor = 16'd3;
    @(negedge clock); lat++;
    bus.start = 1'b0;
    while (!bus.done && lat < 40) begin @(negedge clock); lat++; end
    checkOutput("100/7_lat", lat, 17);
    checkOutput("100/7_q", bus.quotient, 14);
    checkOutput("100/7_r", bus.remainder, 2);

    // Reset sampled at E8 of a fresh operation.
    @(negedge clock);
    bus.start = 1'b1; bus.dividend = 16'd1234; bus.divisor = 16'd10;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (7) @(negedge clock);
    checkOutput("pre_rst_busy", bus.busy, 1);
    reset_n = 1'b0;
    @(negedge clock);
    checkOutput("mid_rst_ready", bus.ready, 1);
    checkOutput("mid_rst_busy", bus.busy, 0);
    checkOutput("mid_rst_done", bus.done, 0);
    checkOutput("mid_rst_q", bus.quotient, 0);
    checkOutput("mid_rst_r", bus.remainder, 0);
    reset_n = 1'b1;
    doneCnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.done) doneCnt++;
    end
    checkOutput("mid_rst_no_done", doneCnt, 0);

`ifdef DIV_SIGNED_EN
    applyStimulus(16'hFFF9, 16'd2, lat, busyCnt);
    checkOutput("s_-7/2_lat", lat, 17);
    checkOutput("s_-7/2_q", bus.quotient, 16'hFFFD);
    checkOutput("s_-7/2_r", bus.remainder, 16'hFFFF);
    applyStimulus(16'h8000, 16'hFFFF, lat, busyCnt);
    checkOutput("s_min/-1_q", bus.quotient, 16'h8000);
    checkOutput("s_min/-1_r", bus.remainder, 0);
    applyStimulus(16'hFFF9, 16'd0, lat, busyCnt);
    checkOutput("s_-7/0_q", bus.quotient, 16'hFFFF);
    checkOutput("s_-7/0_r", bus.remainder, 16'hFFF9);
    checkOutput("s_-7/0_dbz", bus.div_by_zero, 1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised sequential unsigned integer divider with a run-time divisor. It generalises the fixed divide-by-10 repeated-subtraction datapath/controller pair into a single block with a fixed-latency restoring shift-subtract loop, quotient and remainder outputs, and a start/ready/done handshake. It sits beside the existing arithmetic datapaths and is driven by a host FSM or testbench.

## Interface
- `WIDTH`, default 16: operand, quotient and remainder width in bits; must be ≥ 2.
- `clock`  input  1: rising-edge clock for all state.
- `reset_n`  input  1: synchronous, active-low reset, sampled on `clock` rising edge.
- `start`  input  1: request; accepted only when `ready`=1.
- `dividend`  input  WIDTH: numerator, sampled on the accepting edge.
- `divisor`  input  WIDTH: denominator, sampled on the accepting edge.
- `ready`  output  1: block idle and able to accept `start`.
- `busy`  output  1: division in progress.
- `done`  output  1: one-cycle pulse; `quotient`/`remainder`/`div_by_zero` valid.
- `quotient`  output  WIDTH: result, held until the next accepted `start`.
- `remainder`  output  WIDTH: result, held until the next accepted `start`.
- `div_by_zero`  output  1: set with `done` when the latched divisor was 0; held with the results.

## Operation
- Clock is `clock`; reset is synchronous, active-low on `reset_n`.
- States: IDLE, RUN, FIN.
- IDLE: `ready`=1. `start`=1 latches both operands and clears `div_by_zero`. Divisor ≠ 0 → RUN with iteration counter = 0. Divisor = 0 → FIN directly.
- RUN: one restoring step per cycle, MSB first. The partial remainder R is WIDTH+1 bits:
  - R = {R[WIDTH-1:0], next dividend bit}.
  - If R ≥ divisor: R = R − divisor and the quotient bit is 1; otherwise R is unchanged and the bit is 0.
  - Counter ++. After the WIDTH-th step → FIN.
- FIN: `done`=1 for exactly this cycle; outputs are loaded/valid. Next edge → IDLE unconditionally.
- Divide by zero: `quotient` = all ones, `remainder` = dividend, `div_by_zero`=1.
- `start` while in RUN or FIN is ignored; there is no queueing.
- Operand inputs are don't-care except on the accepting edge.
- `reset_n`=0, including mid-RUN: state → IDLE and the counter is cleared. All outputs take their reset values on that edge and the in-flight operation is discarded.
- Reset values:
  - `ready`=1, `busy`=0, `done`=0, `div_by_zero`=0.
  - `quotient`=0, `remainder`=0.
- Counter width is clog2(WIDTH+1). Quotient never overflows in unsigned mode.

## Timing
- Start accepted on edge E0.
- RUN occupies the cycles after edges E0..E(WIDTH−1).
- `done` is high in the cycle after edge E(WIDTH), i.e. WIDTH+1 cycles after acceptance.
- Divide by zero: `done` is high in the cycle after E0 (latency 1).
- `busy`=1 exactly while in RUN. `ready`=1 only in IDLE, which is 0 during FIN.
- Back-to-back throughput: one operation per WIDTH+2 cycles (E0, WIDTH steps, FIN).
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

## Configuration
- `DIV_SIGNED_EN` defined: operands are two's complement.
  - Magnitudes are taken at load and the unsigned core runs unchanged, so latency is identical.
  - Quotient truncates toward zero and is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Overflow: MIN / −1 gives `quotient`=MIN, `remainder`=0.
  - Divide by zero: `quotient`=−1 (all ones), `remainder`=dividend, `div_by_zero`=1.
- `DIV_SIGNED_EN` undefined: unsigned only; no sign logic is synthesised.

## Test plan
- WIDTH=16, unsigned, 1234 / 10: `start` at E0 → `done` after E16 with `quotient`=123, `remainder`=4, `div_by_zero`=0; `busy` high for 16 cycles.
- 0xFFFF / 1 → `quotient`=0xFFFF, `remainder`=0. Then 3 / 10 → `quotient`=0, `remainder`=3.
- 7 / 0 → `done` one cycle after E0, `quotient`=0xFFFF, `remainder`=7, `div_by_zero`=1.
- Start 100 / 7. Pulse `start` with 9 / 3 at E5 → ignored; result is `quotient`=14, `remainder`=2. Then `reset_n`=0 at E8 of a new operation → next cycle `ready`=1, `busy`=0, outputs 0, and no `done`.
- With `DIV_SIGNED_EN`:
  - −7 / 2 → `quotient`=0xFFFD, `remainder`=0xFFFF.
  - 0x8000 / 0xFFFF → `quotient`=0x8000, `remainder`=0.
